// File: rtl/instr_fetch_unit.sv
// Single-clock instruction fetch: owns the PC, drives a 1-cycle synchronous ROM and feeds the
// processor through a 2-entry skid FIFO with valid/ready. Optional FetchCount via IFU_FETCH_COUNT_EN.
module instr_fetch_unit #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 9,
  parameter int LAST_ADDR = 2**ADDR_W-1,
  parameter int WRAP      = 1
)(
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic              LoadEn,
  input  logic [ADDR_W-1:0] LoadAddr,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemEn,
  input  logic [DATA_W-1:0] MemData,
  output logic [DATA_W-1:0] Instr,
  output logic [ADDR_W-1:0] InstrAddr,
  output logic              InstrValid,
  input  logic              InstrReady,
  output logic              Halted
`ifdef IFU_FETCH_COUNT_EN
  ,
  output logic [15:0]       FetchCount
`endif
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_inc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_addr;
  logic [DATA_W-1:0] fifo_data [2];
  logic [ADDR_W-1:0] fifo_addr [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        count;
  logic              issue, credit, pop, push, pc_last;

  assign pop     = InstrValid & InstrReady;
  assign push    = inflight & ~LoadEn;
  assign pc_last = (pc == LAST);
  // Issue only when the word it produces is guaranteed a FIFO slot on arrival.
  assign credit  = ({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});

  always_comb begin
    if (!pc_last)      pc_inc = pc + 1'b1;
    else if (WRAP != 0) pc_inc = '0;
    else               pc_inc = pc;
  end

  // State register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (Run) state_nxt = RUN;
      RUN: begin
        if (!Run)                                 state_nxt = IDLE;
        else if (issue && pc_last && (WRAP == 0)) state_nxt = HALT;
      end
      HALT: if (LoadEn) state_nxt = Run ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    issue  = (state == RUN) && Run && !LoadEn && credit;
    MemEn  = issue;
    Halted = (state == HALT);
  end

  assign MemAddr = pc;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pc            <= '0;
      inflight      <= 1'b0;
      inflight_addr <= '0;
    end else begin
      if (LoadEn)     pc <= LoadAddr;
      else if (issue) pc <= pc_inc;
      inflight <= issue;
      if (issue) inflight_addr <= pc;
    end
  end

  // Flush on LoadEn wins over any push/pop in the same cycle.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else if (LoadEn) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge Clock) begin
    if (push) begin
      fifo_data[wr_ptr] <= MemData;
      fifo_addr[wr_ptr] <= inflight_addr;
    end
  end

  assign InstrValid = (count != 2'd0);
  assign Instr      = InstrValid ? fifo_data[rd_ptr] : '0;
  assign InstrAddr  = InstrValid ? fifo_addr[rd_ptr] : '0;

`ifdef IFU_FETCH_COUNT_EN
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)  FetchCount <= '0;
    else if (pop) FetchCount <= FetchCount + 16'd1;
  end
`endif

endmodule
